// File: rtl/cache_control.sv
// Control FSM for the LC-3b 2-way set-associative write-back cache: decodes hits, sequences
// writeback/allocate transfers to physical memory and keeps saturating hit/miss counters.
module cache_control #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 lru,
  input  logic                 victim_dirty,
  input  logic                 pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 pmem_addr_sel,
  output logic                 data_sel,
  output logic [1:0]           load_data,
  output logic [1:0]           load_tag,
  output logic [1:0]           set_valid,
  output logic [1:0]           set_dirty,
  output logic [1:0]           clear_dirty,
  output logic                 load_lru,
  output logic                 lru_in,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {StCheck, StWriteback, StAllocate} state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 refill_q, refill_d;
  logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

  logic req, is_write, hit, hit_way;

  // A simultaneous read and write is handled as a read.
  assign req      = mem_read | mem_write;
  assign is_write = mem_write & ~mem_read;
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d       = state_q;
    refill_d      = refill_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_sel      = 1'b0;
    load_data     = 2'b00;
    load_tag      = 2'b00;
    set_valid     = 2'b00;
    set_dirty     = 2'b00;
    clear_dirty   = 2'b00;
    load_lru      = 1'b0;
    lru_in        = 1'b0;

    unique case (state_q)
      StCheck: begin
        refill_d = 1'b0;
        if (req && hit) begin
          mem_resp = 1'b1;
          load_lru = 1'b1;
          lru_in   = ~hit_way;
          if (is_write) begin
            load_data[hit_way] = 1'b1;
            set_dirty[hit_way] = 1'b1;
          end
          // The hit that completes a refilled miss was already counted as a miss.
          if (!refill_q && hit_count_q != CntMax) hit_count_d = hit_count_q + CntOne;
        end else if (req) begin
          if (miss_count_q != CntMax) miss_count_d = miss_count_q + CntOne;
          state_d = victim_dirty ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) state_d = StAllocate;
      end
      StAllocate: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_sel         = 1'b1;
          load_data[lru]   = 1'b1;
          load_tag[lru]    = 1'b1;
          set_valid[lru]   = 1'b1;
          clear_dirty[lru] = 1'b1;
          state_d          = StCheck;
          refill_d         = 1'b1;
        end
      end
      default: state_d = StCheck;
    endcase

    if (rst) begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      data_sel      = 1'b0;
      load_data     = 2'b00;
      load_tag      = 2'b00;
      set_valid     = 2'b00;
      set_dirty     = 2'b00;
      clear_dirty   = 2'b00;
      load_lru      = 1'b0;
      lru_in        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StCheck;
      refill_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      refill_q     <= refill_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the cache controller.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, hit0, hit1, lru, victim_dirty, pmem_resp;

  logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel, load_lru, lru_in;
  logic [1:0]  load_data, load_tag, set_valid, set_dirty, clear_dirty;
  logic [15:0] hit_count, miss_count;

  logic        s_mem_resp, s_pmem_read, s_pmem_write, s_pmem_addr_sel, s_data_sel;
  logic        s_load_lru, s_lru_in;
  logic [1:0]  s_load_data, s_load_tag, s_set_valid, s_set_dirty, s_clear_dirty;
  logic [3:0]  s_hit_count, s_miss_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_control dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit0(hit0), .hit1(hit1), .lru(lru), .victim_dirty(victim_dirty), .pmem_resp(pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
    .data_sel(data_sel), .load_data(load_data), .load_tag(load_tag), .set_valid(set_valid),
    .set_dirty(set_dirty), .clear_dirty(clear_dirty), .load_lru(load_lru), .lru_in(lru_in),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation coverage.
  cache_control #(.CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(s_mem_resp),
    .hit0(hit0), .hit1(hit1), .lru(lru), .victim_dirty(victim_dirty), .pmem_resp(pmem_resp),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_addr_sel(s_pmem_addr_sel),
    .data_sel(s_data_sel), .load_data(s_load_data), .load_tag(s_load_tag),
    .set_valid(s_set_valid), .set_dirty(s_set_dirty), .clear_dirty(s_clear_dirty),
    .load_lru(s_load_lru), .lru_in(s_lru_in), .hit_count(s_hit_count),
    .miss_count(s_miss_count)
  );

  logic [16:0] act_v, act_s;
  assign act_v = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel, load_data, load_tag,
                  set_valid, set_dirty, clear_dirty, load_lru, lru_in};
  assign act_s = {s_mem_resp, s_pmem_read, s_pmem_write, s_pmem_addr_sel, s_data_sel,
                  s_load_data, s_load_tag, s_set_valid, s_set_dirty, s_clear_dirty, s_load_lru,
                  s_lru_in};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Model: what the controller is doing at the transaction level.
  bit          m_writing_back = 0, m_filling = 0, m_after_fill = 0;
  int unsigned m_hits = 0, m_misses = 0;

  function automatic logic [31:0] sat(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(negedge clk) begin
    logic        e_resp, e_pr, e_pw, e_asel, e_dsel, e_llru, e_lruin;
    logic [1:0]  e_ld, e_lt, e_sv, e_sd, e_cd;
    logic [16:0] exp_v, care;
    bit          req, wr, hit;
    int          way;
    e_resp = 0; e_pr = 0; e_pw = 0; e_asel = 0; e_dsel = 0; e_llru = 0; e_lruin = 0;
    e_ld = 0; e_lt = 0; e_sv = 0; e_sd = 0; e_cd = 0;
    req = mem_read || mem_write;
    wr  = mem_write && !mem_read;
    hit = hit0 || hit1;
    way = hit0 ? 0 : 1;
    if (!rst) begin
      if (m_writing_back) begin
        e_pw = 1; e_asel = 1;
      end else if (m_filling) begin
        e_pr = 1; e_asel = 0;
        if (pmem_resp) begin
          e_dsel = 1;
          e_ld[lru] = 1; e_lt[lru] = 1; e_sv[lru] = 1; e_cd[lru] = 1;
        end
      end else if (req && hit) begin
        e_resp = 1; e_llru = 1; e_lruin = (way == 0);
        if (wr) begin e_ld[way] = 1; e_sd[way] = 1; e_dsel = 0; end
      end
    end
    exp_v = {e_resp, e_pr, e_pw, e_asel, e_dsel, e_ld, e_lt, e_sv, e_sd, e_cd, e_llru, e_lruin};
    // Selects matter only while the strobe they steer is active.
    care = 17'h1ffff;
    care[13] = e_pr | e_pw;
    care[12] = |e_ld;
    care[0]  = e_llru;
    chk("outputs", 32'(act_v & care), 32'(exp_v & care));
    chk("outputs_w4", 32'(act_s & care), 32'(exp_v & care));
    chk("hit_count", 32'(hit_count), sat(m_hits, 65535));
    chk("miss_count", 32'(miss_count), sat(m_misses, 65535));
    chk("hit_count_w4", 32'(s_hit_count), sat(m_hits, 15));
    chk("miss_count_w4", 32'(s_miss_count), sat(m_misses, 15));

    if (rst) begin
      m_writing_back = 0; m_filling = 0; m_after_fill = 0; m_hits = 0; m_misses = 0;
    end else if (m_writing_back) begin
      if (pmem_resp) begin m_writing_back = 0; m_filling = 1; end
    end else if (m_filling) begin
      if (pmem_resp) begin m_filling = 0; m_after_fill = 1; end
    end else begin
      if (req && hit && !m_after_fill) m_hits++;
      if (req && !hit) begin
        m_misses++;
        if (victim_dirty) m_writing_back = 1; else m_filling = 1;
      end
      m_after_fill = 0;
    end
  end

  task automatic drive(input bit r, input bit w, input bit h0, input bit h1, input bit l,
                       input bit vd, input bit pr, input bit rs);
    mem_read = r; mem_write = w; hit0 = h0; hit1 = h1; lru = l; victim_dirty = vd;
    pmem_resp = pr; rst = rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step(); step();

    // Read hit in way1.
    drive(1, 0, 0, 1, 1, 0, 0, 0); #1;
    chk("t1_mem_resp", 32'(mem_resp), 1);
    chk("t1_load_lru", 32'(load_lru), 1);
    chk("t1_lru_in", 32'(lru_in), 0);
    chk("t1_load_data", 32'(load_data), 0);
    step();
    chk("t1_hit_count", 32'(hit_count), 1);

    // Write hit in way0.
    drive(0, 1, 1, 0, 0, 0, 0, 0); #1;
    chk("t2_mem_resp", 32'(mem_resp), 1);
    chk("t2_load_data", 32'(load_data), 1);
    chk("t2_set_dirty", 32'(set_dirty), 1);
    chk("t2_data_sel", 32'(data_sel), 0);
    chk("t2_lru_in", 32'(lru_in), 1);
    step();

    // Clean read miss, fill into way0 after 5 wait cycles.
    drive(1, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("t3_miss_resp", 32'(mem_resp), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_pmem_read", 32'({pmem_read, pmem_write}), 2'b10);
      step();
    end
    pmem_resp = 1; #1;
    chk("t3_load_data", 32'(load_data), 1);
    chk("t3_load_tag", 32'(load_tag), 1);
    chk("t3_set_valid", 32'(set_valid), 1);
    chk("t3_clear_dirty", 32'(clear_dirty), 1);
    chk("t3_data_sel", 32'(data_sel), 1);
    step();
    drive(1, 0, 1, 0, 0, 0, 0, 0); #1;
    chk("t3_refill_resp", 32'(mem_resp), 1);
    step();
    chk("t3_miss_count", 32'(miss_count), 1);
    chk("t3_hit_count", 32'(hit_count), 2);

    // Dirty write miss: writeback, then fill way1, then write hit.
    drive(0, 1, 0, 0, 1, 1, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t4_writeback", 32'({pmem_write, pmem_addr_sel, pmem_read}), 3'b110);
      step();
    end
    pmem_resp = 1;
    step();
    #1;
    chk("t4_fill_way1", 32'({pmem_read, load_data}), 3'b110);
    step();
    drive(0, 1, 0, 1, 0, 0, 0, 0); #1;
    chk("t4_wr_load_data", 32'(load_data), 2);
    chk("t4_wr_set_dirty", 32'(set_dirty), 2);
    step();
    chk("t4_hit_count", 32'(hit_count), 2);
    chk("t4_miss_count", 32'(miss_count), 2);

    // Reset in the 3rd writeback cycle.
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    step(); step(); step();
    rst = 1; #1;
    chk("t5_pmem_write", 32'(pmem_write), 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("t5_hit_count", 32'(hit_count), 0);
    chk("t5_miss_count", 32'(miss_count), 0);
    chk("t5_strobes", 32'({pmem_read, pmem_write, mem_resp, load_data, load_tag, set_valid,
                           set_dirty, clear_dirty, load_lru}), 0);
    step();

    // 16 hits saturate the 4-bit counter.
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step();
    chk("t6_sat_hit_count", 32'(s_hit_count), 15);
    chk("t6_wide_hit_count", 32'(hit_count), 16);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- FSM that sequences the LC-3b 2-way set-associative, write-back/write-allocate cache datapath between the CPU (16-bit word bus) and physical memory (128-bit line bus).
- Decodes hit/miss from datapath status and drives the datapath load/select strobes, the pmem handshake and the LRU update.
- Returns mem_resp to the CPU.
- Keeps saturating hit/miss counters for performance checks.

Parameters:
- CNT_WIDTH, 16, width of hit_count and miss_count.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  CPU transaction complete (one cycle per transaction)
- hit0  in  1  datapath: way0 valid and tag match for current index
- hit1  in  1  datapath: way1 valid and tag match
- lru  in  1  datapath: LRU way of current set (0 = way0 is victim)
- victim_dirty  in  1  datapath: dirty bit of way[lru]
- pmem_resp  in  1  physical memory done
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_addr_sel  out  1  0 = CPU address, 1 = {victim tag, index, 0000}
- data_sel  out  1  0 = merge CPU word per byte enable, 1 = pmem line
- load_data  out  2  per-way data array write enable
- load_tag  out  2  per-way tag write enable
- set_valid  out  2  per-way valid set
- set_dirty  out  2  per-way dirty set
- clear_dirty  out  2  per-way dirty clear
- load_lru  out  1  LRU array write enable
- lru_in  out  1  value written to LRU (way NOT just used)
- hit_count  out  CNT_WIDTH  CPU hits since reset
- miss_count  out  CNT_WIDTH  misses since reset

Behaviour:
- States: CHECK (reset state), WRITEBACK, ALLOCATE. One internal flag, refill.
- Outputs are combinational from state and inputs. While rst=1, every output strobe and mem_resp is forced to 0.
- On the reset edge:
  - state becomes CHECK.
  - refill becomes 0.
  - both counters become 0.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE abandons the transfer. pmem_read and pmem_write are 0 from the reset cycle onward.
- CHECK, no request: all strobes 0; stay.
- CHECK, request with hit (hit0 or hit1; hit0 wins if both set). Let w be the hit way.
  - mem_resp=1 and load_lru=1 in the same cycle. lru_in = ~w.
  - Write hit: load_data[w]=1, set_dirty[w]=1, data_sel=0.
  - Read hit: no data strobe.
  - Stay in CHECK. Hit latency is 1 cycle from request.
- mem_read and mem_write both asserted is treated as a read.
- CHECK, request with miss: no mem_resp; miss_count increments.
  - victim_dirty=1 → WRITEBACK.
  - victim_dirty=0 → ALLOCATE.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1.
  - Hold until pmem_resp=1, then → ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_addr_sel=0. Let v = lru as sampled in this state.
  - On pmem_resp=1, in the same cycle: load_data[v]=1, data_sel=1, load_tag[v]=1, set_valid[v]=1, clear_dirty[v]=1.
  - Then → CHECK with refill=1.
- CHECK with refill=1: processed as above, but the resulting hit does not increment hit_count. refill is cleared on any cycle in CHECK.
- hit_count increments on each counted hit.
- Both counters saturate at all-ones; they never wrap.
- pmem_read and pmem_write are never asserted together and never asserted in CHECK.
- Unused strobe bits are 0 in every state.

Test Plan:
1. Reset, then mem_read=1 with hit1=1, lru=1 → same cycle: mem_resp=1, load_lru=1, lru_in=0, load_data=00; hit_count=1.
2. Write hit way0 → mem_resp=1, load_data=01, set_dirty=01, data_sel=0, lru_in=1.
3. Clean read miss (hit0=hit1=0, lru=0, victim_dirty=0), pmem_resp after 5 cycles:
   - ALLOCATE with pmem_read=1 for 5 cycles.
   - Resp cycle: load_data=01, load_tag=01, set_valid=01, clear_dirty=01, data_sel=1.
   - Next CHECK with hit0=1: mem_resp=1; miss_count=1, hit_count unchanged.
4. Dirty write miss, lru=1, victim_dirty=1:
   - WRITEBACK with pmem_write=1, pmem_addr_sel=1 until pmem_resp.
   - Then ALLOCATE filling way1.
   - Then CHECK write hit: load_data=10, set_dirty=10.
5. rst=1 in the 3rd cycle of WRITEBACK → that cycle pmem_write=0; next cycle state CHECK, counters 0, no strobes without a request.
6. Force hit_count to the limit with CNT_WIDTH=4: 16 hits → hit_count stays 15.
